pixel_stream_writer: RTL and testbench
======================================

# pixel_stream_writer

Byte-stream front end that fills the write port of the 4096×16 `pixel_ram` feeding `panel_driver`. It accepts 8-bit pixel bytes over a valid/ready handshake and assembles RGB565 words, high byte first. It writes them linearly into RAM from address 0 to 4095 and reports frame completion and framing errors. It sits between the external data source (UART/SPI byte receiver) and `pixel_ram`'s `i_w_*` ports, all in the `clk_48mhz` domain.

## Interface
- `PIXELS`, 4096: words per frame; must be ≤ 2^`ADDR_W`
- `ADDR_W`, 12: RAM address width
- `i_clk` in 1: system clock, `clk_48mhz`; one clock domain; reset is synchronous and active-high
- `i_reset` in 1: synchronous, active-high reset
- `i_data` in 8: stream byte
- `i_valid` in 1: `i_data` valid
- `i_sof` in 1: start of frame; qualified by `i_valid`; marks the first (high) byte of pixel 0
- `o_ready` in/out: out 1: byte accepted when `i_valid && o_ready`
- `o_w_addr` out `ADDR_W`: RAM write address
- `o_w_data` out 16: RAM write data, `{hi_byte, lo_byte}`
- `o_w_enable` out 1: one-cycle RAM write strobe
- `o_frame_done` out 1: one-cycle pulse on the final write of a frame
- `o_frame_count` out 8: completed frames, wraps 255→0
- `o_resync` out 1: one-cycle pulse when `i_sof` arrives mid-frame
- `o_drop` out 1: one-cycle pulse when a byte is discarded in IDLE

## Operation
- States:
  - IDLE: waiting for `i_sof`
  - HI: expecting high byte
  - LO: expecting low byte
- `o_ready` is 1 in every state except the cycle `i_reset` is high (combinational `~i_reset`).
- IDLE:
  - Accepted byte with `i_sof`=1: latch as hi byte, clear pixel index, go to LO.
  - Accepted byte with `i_sof`=0: discard, pulse `o_drop`, stay in IDLE.
- HI: accepted byte latched as hi byte, go to LO. `i_sof`=1 here is a resync (see below).
- LO: accepted byte completes the pixel.
  - Next cycle: `o_w_enable`=1, `o_w_addr`=pixel index, `o_w_data`={hi,lo}.
  - Index increments.
  - If the index was `PIXELS-1`, pulse `o_frame_done` together with that write, increment `o_frame_count`, and go to IDLE. Otherwise go to HI.
- Resync: accepted byte with `i_sof`=1 in HI or LO.
  - Treat it as the high byte of pixel 0: index←0, go to LO, pulse `o_resync`.
  - The partial pixel is discarded; no write is issued for it.
  - Already-written words remain in RAM.
- `i_sof` on a non-accepted cycle (`i_valid`=0) is ignored.
- Pixel index is `ADDR_W` bits; it never exceeds `PIXELS-1`.
- Write data and address are registered; outputs hold their last values when `o_w_enable`=0.

## Timing
- Reset values:
  - state IDLE
  - index 0
  - `o_w_enable`, `o_frame_done`, `o_resync`, `o_drop`, `o_frame_count` all 0
  - `o_w_addr` 0, `o_w_data` 0
- Reset mid-frame: next cycle is IDLE with no write strobe. A write already scheduled for the reset cycle is suppressed.
- Throughput: one byte per cycle sustained, i.e. one RAM write every 2 cycles.
- Latency: low byte accepted at cycle N → `o_w_enable` at N+1.
- `o_frame_done` is coincident with the write of address `PIXELS-1`.
- `o_frame_count` updates at the same edge that raises `o_frame_done`.
- `o_resync` and `o_drop` assert the cycle after the offending byte is accepted.
- Frame back-to-back: sof byte may be accepted the cycle after the last low byte. IDLE is entered at that edge, so the sof byte is accepted in IDLE normally.
- The panel driver reads RAM concurrently. No tearing protection is provided; mid-frame contents are a mix of old and new frames.

## Test plan
- Reset, then a full frame of 8192 bytes where pixel k = k[11:0]·16+0x3 pattern, sof on byte 0, `i_valid` held high → 4096 writes, addr 0..4095 in order, data matches, `o_frame_done` once with addr 4095, `o_frame_count`=1.
- 3 bytes 0x11,0x22,0x33 without sof in IDLE → three `o_drop` pulses, no `o_w_enable`.
- Bytes with sof: 0xAB,0xCD, then `i_valid` toggled 1/0 every cycle → write addr 0 data 0xABCD exactly 1 cycle after 0xCD accepted; gaps do not create extra writes.
- Mid-frame resync: after 10 pixels plus a lone hi byte, send sof byte 0x12 then 0x34 → `o_resync` pulse, next write addr 0 data 0x1234, no write for the orphan byte.
- `i_reset` pulsed on the cycle a low byte is accepted at pixel 5 → no write, state IDLE, all outputs at reset values. A following sof frame starts at addr 0.
- 256 complete frames → `o_frame_count` wraps to 0 and 256 `o_frame_done` pulses are seen.

Source files
------------

// File: rtl/pixel_stream_writer.sv
// Byte-stream front end for pixel_ram: pairs 8-bit bytes into RGB565 words (high byte first)
// and writes them linearly from address 0, flagging frame completion, resyncs and drops.
module pixel_stream_writer #(
  parameter int PIXELS = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  input  logic              i_sof,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic [15:0]       o_w_data,
  output logic              o_w_enable,
  output logic              o_frame_done,
  output logic [7:0]        o_frame_count,
  output logic              o_resync,
  output logic              o_drop
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HI   = 2'd1;
  localparam logic [1:0] ST_LO   = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(PIXELS - 1);
  localparam logic [ADDR_W-1:0] INDEX_ONE  = ADDR_W'(1);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] index_next;
  logic [7:0]        hi_byte;
  logic              accept;
  logic              load_hi;
  logic              write_now;
  logic              last_now;
  logic              resync_now;
  logic              drop_now;

  // Always ready except while reset is held.
  assign o_ready = ~i_reset;
  assign accept  = i_valid & o_ready;

  // Next-state and per-byte event decode.
  always_comb begin
    state_next = state;
    index_next = index;
    load_hi    = 1'b0;
    write_now  = 1'b0;
    last_now   = 1'b0;
    resync_now = 1'b0;
    drop_now   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && i_sof) begin
          load_hi    = 1'b1;
          index_next = '0;
          state_next = ST_LO;
        end else if (accept) begin
          drop_now = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_HI: begin
        if (accept && i_sof) begin
          load_hi    = 1'b1;
          index_next = '0;
          resync_now = 1'b1;
          state_next = ST_LO;
        end else if (accept) begin
          load_hi    = 1'b1;
          state_next = ST_LO;
        end else begin
          state_next = ST_HI;
        end
      end
      ST_LO: begin
        if (accept && i_sof) begin
          // sof mid-pixel: the pending hi byte is abandoned, this byte restarts pixel 0
          load_hi    = 1'b1;
          index_next = '0;
          resync_now = 1'b1;
          state_next = ST_LO;
        end else if (accept) begin
          write_now = 1'b1;
          if (index == LAST_INDEX) begin
            last_now   = 1'b1;
            index_next = '0;
            state_next = ST_IDLE;
          end else begin
            index_next = index + INDEX_ONE;
            state_next = ST_HI;
          end
        end else begin
          state_next = ST_LO;
        end
      end
      default: begin
        index_next = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, pixel assembly and registered RAM write port.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      index         <= '0;
      hi_byte       <= 8'h00;
      o_w_addr      <= '0;
      o_w_data      <= 16'h0000;
      o_w_enable    <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_count <= 8'h00;
      o_resync      <= 1'b0;
      o_drop        <= 1'b0;
    end else begin
      state        <= state_next;
      index        <= index_next;
      o_w_enable   <= write_now;
      o_frame_done <= last_now;
      o_resync     <= resync_now;
      o_drop       <= drop_now;
      if (load_hi) begin
        hi_byte <= i_data;
      end
      if (write_now) begin
        o_w_addr <= index;
        o_w_data <= {hi_byte, i_data};
      end
      if (last_now) begin
        o_frame_count <= o_frame_count + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Scoreboard bench for pixel_stream_writer: expected writes are queued by the stimulus
// and popped by a negedge monitor; a small-frame instance covers frame counter wrap.
module tb_pixel_stream_writer;

  logic        clk;
  logic        rst;
  logic [7:0]  data;
  logic        valid;
  logic        sof;
  logic        ready;
  logic [11:0] w_addr;
  logic [15:0] w_data;
  logic        w_en;
  logic        done;
  logic [7:0]  fcount;
  logic        resync;
  logic        drop;

  logic [7:0]  data2;
  logic        valid2;
  logic        sof2;
  logic        ready2;
  logic [1:0]  w_addr2;
  logic [15:0] w_data2;
  logic        w_en2;
  logic        done2;
  logic [7:0]  fcount2;
  logic        resync2;
  logic        drop2;

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] wdata;
    logic        last;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_writes = 0;
  int n_done = 0;
  int n_drop = 0;
  int n_resync = 0;
  int n_writes2 = 0;
  int n_done2 = 0;

  pixel_stream_writer #(.PIXELS(4096), .ADDR_W(12)) dut (
    .i_clk(clk), .i_reset(rst), .i_data(data), .i_valid(valid), .i_sof(sof),
    .o_ready(ready), .o_w_addr(w_addr), .o_w_data(w_data), .o_w_enable(w_en),
    .o_frame_done(done), .o_frame_count(fcount), .o_resync(resync), .o_drop(drop)
  );

  pixel_stream_writer #(.PIXELS(4), .ADDR_W(2)) dut_small (
    .i_clk(clk), .i_reset(rst), .i_data(data2), .i_valid(valid2), .i_sof(sof2),
    .o_ready(ready2), .o_w_addr(w_addr2), .o_w_data(w_data2), .o_w_enable(w_en2),
    .o_frame_done(done2), .o_frame_count(fcount2), .o_resync(resync2), .o_drop(drop2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the full-size instance: pops the scoreboard on every write.
  always @(negedge clk) begin
    if (w_en === 1'b1) begin
      n_writes++;
      if (q.size() == 0) begin
        check("unexpected_write", {4'h0, w_addr, w_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("write_addr", 32'(w_addr), 32'(e.addr));
        check("write_data", 32'(w_data), 32'(e.wdata));
        check("write_done", 32'(done), 32'(e.last));
      end
    end else if (done === 1'b1) begin
      check("done_without_write", 32'(done), 32'h0);
    end
    if (done === 1'b1) n_done++;
    if (drop === 1'b1) n_drop++;
    if (resync === 1'b1) n_resync++;
  end

  // Monitor for the small instance: frame count must track the done pulses seen.
  always @(negedge clk) begin
    if (w_en2 === 1'b1) n_writes2++;
    if (done2 === 1'b1) begin
      n_done2++;
      check("small_fcount_at_done", 32'(fcount2), 32'(n_done2 % 256));
      check("small_done_addr", 32'(w_addr2), 32'h3);
    end
  end

  task automatic send(input logic [7:0] d, input logic s);
    data = d; sof = s; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send2(input logic [7:0] d, input logic s);
    data2 = d; sof2 = s; valid2 = 1'b1;
    @(posedge clk); #1;
    valid2 = 1'b0; sof2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push(input logic [11:0] a, input logic [15:0] d, input logic l);
    exp_t e;
    e.addr = a; e.wdata = d; e.last = l;
    q.push_back(e);
  endtask

  initial begin
    int base_w;
    int base_d;
    int base_r;
    logic [15:0] px;
    logic [11:0] k12;
    rst = 1'b1; data = 8'h00; valid = 1'b0; sof = 1'b0;
    data2 = 8'h00; valid2 = 1'b0; sof2 = 1'b0;
    idle(2);
    check("ready_in_reset", 32'(ready), 32'h0);
    check("reset_w_en", 32'(w_en), 32'h0);
    check("reset_addr", 32'(w_addr), 32'h0);
    check("reset_data", 32'(w_data), 32'h0);
    check("reset_fcount", 32'(fcount), 32'h0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(ready), 32'h1);

    // Full frame, valid held high.
    for (int k = 0; k < 4096; k++) begin
      k12 = 12'(k);
      px = {k12, 4'h3};
      push(k12, px, k == 4095);
      send(px[15:8], k == 0);
      send(px[7:0], 1'b0);
    end
    idle(2);
    check("frame_writes", 32'(n_writes), 32'd4096);
    check("frame_done_count", 32'(n_done), 32'd1);
    check("frame_count_1", 32'(fcount), 32'h1);

    // Bytes without sof in IDLE are dropped.
    base_w = n_writes;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    idle(2);
    check("drop_count", 32'(n_drop), 32'd3);
    check("drop_no_write", 32'(n_writes - base_w), 32'd0);

    // Gapped stream: write lands exactly one cycle after the low byte.
    push(12'h000, 16'hABCD, 1'b0);
    send(8'hAB, 1'b1);
    idle(1);
    send(8'hCD, 1'b0);
    check("gap_w_en_n1", 32'(w_en), 32'h1);
    check("gap_addr", 32'(w_addr), 32'h0);
    check("gap_data", 32'(w_data), 32'hABCD);
    idle(1);
    check("gap_single_strobe", 32'(w_en), 32'h0);

    // Mid-frame resync after pixels 1..9 and a lone hi byte.
    for (int k = 1; k < 10; k++) begin
      push(12'(k), {8'h10 + 8'(k), 8'h20 + 8'(k)}, 1'b0);
      send(8'h10 + 8'(k), 1'b0);
      idle(1);
      send(8'h20 + 8'(k), 1'b0);
    end
    base_r = n_resync;
    send(8'hEE, 1'b0);
    push(12'h000, 16'h1234, 1'b0);
    send(8'h12, 1'b1);
    send(8'h34, 1'b0);
    idle(2);
    check("resync_pulse", 32'(n_resync - base_r), 32'd1);

    // Reset on the cycle the low byte of pixel 5 is presented.
    for (int k = 1; k < 5; k++) begin
      push(12'(k), {8'h60 + 8'(k), 8'h70 + 8'(k)}, 1'b0);
      send(8'h60 + 8'(k), 1'b0);
      send(8'h70 + 8'(k), 1'b0);
    end
    send(8'h77, 1'b0);
    base_w = n_writes;
    rst = 1'b1; data = 8'h88; valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    check("rst_w_en", 32'(w_en), 32'h0);
    check("rst_addr", 32'(w_addr), 32'h0);
    check("rst_data", 32'(w_data), 32'h0);
    check("rst_fcount", 32'(fcount), 32'h0);
    check("rst_flags", {29'h0, done, resync, drop}, 32'h0);
    idle(1);
    check("rst_no_write", 32'(n_writes - base_w), 32'd0);
    base_d = n_drop;
    send(8'h99, 1'b0);
    idle(1);
    check("rst_state_idle", 32'(n_drop - base_d), 32'd1);
    push(12'h000, 16'h5566, 1'b0);
    send(8'h55, 1'b1);
    send(8'h66, 1'b0);
    idle(2);
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    // 256 back-to-back small frames wrap the frame counter.
    for (int f = 0; f < 256; f++) begin
      for (int p = 0; p < 4; p++) begin
        send2(8'(f), p == 0);
        send2(8'(p), 1'b0);
      end
    end
    idle(2);
    check("small_done_pulses", 32'(n_done2), 32'd256);
    check("small_writes", 32'(n_writes2), 32'd1024);
    check("small_fcount_wrap", 32'(fcount2), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
